// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single-ported data memory between the CPU MEM stage and a
// DMA/debug master. The CPU has priority. A wait counter forces a waiting
// DMA request through after MAX_WAIT lost cycles, so DMA cannot starve.
//
// Configuration macro: DMEM_ARB_BOUNDS_EN
//   defined   : a grant to an address >= DEPTH still completes its handshake,
//               but the memory strobes are suppressed. That port's err pulses
//               the next cycle, and reads return rdata=0 with rvalid.
//   undefined : no bounds check; cpu_err/dma_err tied 0.
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          CPU request (held until cpu_gnt)
//   dma_req/we/addr/wdata          DMA request (held until dma_gnt)
//   cpu_gnt, dma_gnt               combinational grant, access at this edge
//   cpu_rvalid/rdata/err           registered CPU response
//   dma_rvalid/rdata/err           registered DMA response
//   DMEM_address/data_in           memory address / write data
//   DMEM_mem_write/mem_read        memory strobes
//   DMEM_data_out                  memory read data (combinational)
module dmem_arbiter #(
    parameter int DEPTH    = 21,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        cpu_gnt,
    output logic        dma_gnt,
    output logic        cpu_rvalid,
    output logic        dma_rvalid,
    output logic [31:0] cpu_rdata,
    output logic [31:0] dma_rdata,
    output logic        cpu_err,
    output logic        dma_err,
    output logic [31:0] DMEM_address,
    output logic [31:0] DMEM_data_in,
    output logic        DMEM_mem_write,
    output logic        DMEM_mem_read,
    input  logic [31:0] DMEM_data_out
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    if (MAX_WAIT < 1) begin : g_bad_max_wait
        $error("dmem_arbiter: MAX_WAIT must be at least 1");
    end
    if (DEPTH < 1) begin : g_bad_depth
        $error("dmem_arbiter: DEPTH must be at least 1");
    end

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              dma_force;
    logic              cpu_sel, dma_sel, any_sel;
    logic              sel_we, sel_oob;
    logic [31:0]       sel_addr, sel_wdata;
    logic              cpu_rd, dma_rd;

    logic              cpu_rvalid_q, dma_rvalid_q;
    logic [31:0]       cpu_rdata_q, dma_rdata_q;

    // DMA is forced through once it has lost MAX_WAIT cycles in a row.
    // Grants are gated by rst_n so nothing reaches memory during reset.
    assign dma_force = dma_req && (wait_cnt_q == WAIT_W'(MAX_WAIT));
    assign cpu_sel   = rst_n && cpu_req && !dma_force;
    assign dma_sel   = rst_n && dma_req && (dma_force || !cpu_req);
    assign any_sel   = cpu_sel || dma_sel;
    assign cpu_gnt   = cpu_sel;
    assign dma_gnt   = dma_sel;
    assign cpu_rd    = cpu_sel && !cpu_we;
    assign dma_rd    = dma_sel && !dma_we;

    // Winner's qualifiers; everything is zero when nobody is granted.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (dma_sel) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end else if (cpu_sel) begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end
    end

`ifdef DMEM_ARB_BOUNDS_EN
    assign sel_oob = (sel_addr >= 32'(DEPTH));
`else
    assign sel_oob = 1'b0;
`endif

    assign DMEM_address   = sel_addr;
    assign DMEM_data_in   = sel_wdata;
    assign DMEM_mem_write = any_sel && sel_we && !sel_oob;
    assign DMEM_mem_read  = any_sel && !sel_we && !sel_oob;

    // Starvation counter: counts lost DMA cycles, saturating at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!dma_req || dma_sel) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Read data is captured at the grant edge. The losing port keeps its old rdata.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
            dma_rvalid_q <= 1'b0;
            cpu_rdata_q  <= '0;
            dma_rdata_q  <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            cpu_rvalid_q <= cpu_rd;
            dma_rvalid_q <= dma_rd;
            if (cpu_rd) begin
                cpu_rdata_q <= sel_oob ? 32'd0 : DMEM_data_out;
            end
            if (dma_rd) begin
                dma_rdata_q <= sel_oob ? 32'd0 : DMEM_data_out;
            end
        end
    end

    assign cpu_rvalid = cpu_rvalid_q;
    assign dma_rvalid = dma_rvalid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

`ifdef DMEM_ARB_BOUNDS_EN
    logic cpu_err_q, dma_err_q;

    // One-cycle error pulse following an out-of-range grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_err_q <= 1'b0;
            dma_err_q <= 1'b0;
        end else begin
            cpu_err_q <= cpu_sel && sel_oob;
            dma_err_q <= dma_sel && sel_oob;
        end
    end

    assign cpu_err = cpu_err_q;
    assign dma_err = dma_err_q;
`else
    assign cpu_err = 1'b0;
    assign dma_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a scoreboard. The stimulus process
// checks grants and memory strobes in the cycle they occur. It queues the
// expected registered response for each port. A negedge monitor pops those
// entries when they fall due and compares rvalid/err/rdata.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_BOUNDS_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, cpu_err, dma_err;
    logic [31:0] cpu_rdata, dma_rdata;
    logic [31:0] DMEM_address, DMEM_data_in, DMEM_data_out;
    logic        DMEM_mem_write, DMEM_mem_read;

    typedef struct {
        int          due;
        logic        rv;
        logic        err;
        logic [31:0] data;
    } resp_t;

    resp_t cpuQ[$];
    resp_t dmaQ[$];
    int    nChecks   = 0;
    int    nFailures = 0;
    int    cycleCnt  = 0;

    logic [31:0] mem [0:31];

    dmem_arbiter #(.DEPTH(21), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
        .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
        .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
        .cpu_err(cpu_err), .dma_err(dma_err),
        .DMEM_address(DMEM_address), .DMEM_data_in(DMEM_data_in),
        .DMEM_mem_write(DMEM_mem_write), .DMEM_mem_read(DMEM_mem_read),
        .DMEM_data_out(DMEM_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Behavioural data memory: word i preloaded with 0xA0000000+i, word 7 = 0x12345678.
    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + 32'(i);
        mem[7] <= 32'h1234_5678;
    end
    always @(posedge clk) if (DMEM_mem_write) mem[DMEM_address[4:0]] <= DMEM_data_in;
    assign DMEM_data_out = mem[DMEM_address[4:0]];

    // Single comparison point; every check flows through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFailures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                                 input logic [31:0] cWdata, input logic dReq, input logic dWe,
                                 input logic [31:0] dAddr, input logic [31:0] dWdata);
        cpu_req = cReq; cpu_we = cWe; cpu_addr = cAddr; cpu_wdata = cWdata;
        dma_req = dReq; dma_we = dWe; dma_addr = dAddr; dma_wdata = dWdata;
    endtask

    // Queue a registered response due the cycle after the upcoming grant edge.
    task automatic expectResp(input bit isCpu, input logic rv, input logic err, input logic [31:0] data);
        resp_t e;
        e.due = cycleCnt + 1; e.rv = rv; e.err = err; e.data = data;
        if (isCpu) cpuQ.push_back(e);
        else       dmaQ.push_back(e);
    endtask

    // Check grants and memory-side outputs mid-cycle, then advance past the edge.
    task automatic runCycle(input string tag, input logic eCpu, input logic eDma,
                            input logic [31:0] eAddr, input logic [31:0] eWdata,
                            input logic eWr, input logic eRd);
        @(negedge clk);
        checkOutput({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'(eCpu));
        checkOutput({tag, ".dma_gnt"}, 32'(dma_gnt), 32'(eDma));
        checkOutput({tag, ".addr"}, DMEM_address, eAddr);
        checkOutput({tag, ".wdata"}, DMEM_data_in, eWdata);
        checkOutput({tag, ".mem_write"}, 32'(DMEM_mem_write), 32'(eWr));
        checkOutput({tag, ".mem_read"}, 32'(DMEM_mem_read), 32'(eRd));
        @(posedge clk);
        #1;
    endtask

    // Response monitor: pops due entries, otherwise requires the port to be quiet.
    always @(negedge clk) begin : monitor
        resp_t e;
        if (rst_n) begin
            if (cpuQ.size() != 0 && cpuQ[0].due <= cycleCnt) begin
                e = cpuQ.pop_front();
                checkOutput("cpu_resp_due", 32'(cycleCnt), 32'(e.due));
                checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(e.rv));
                checkOutput("cpu_err", 32'(cpu_err), 32'(e.err));
                if (e.rv) checkOutput("cpu_rdata", cpu_rdata, e.data);
            end else begin
                checkOutput("cpu_rvalid_idle", 32'(cpu_rvalid), 32'd0);
                checkOutput("cpu_err_idle", 32'(cpu_err), 32'd0);
            end
            if (dmaQ.size() != 0 && dmaQ[0].due <= cycleCnt) begin
                e = dmaQ.pop_front();
                checkOutput("dma_resp_due", 32'(cycleCnt), 32'(e.due));
                checkOutput("dma_rvalid", 32'(dma_rvalid), 32'(e.rv));
                checkOutput("dma_err", 32'(dma_err), 32'(e.err));
                if (e.rv) checkOutput("dma_rdata", dma_rdata, e.data);
            end else begin
                checkOutput("dma_rvalid_idle", 32'(dma_rvalid), 32'd0);
                checkOutput("dma_err_idle", 32'(dma_err), 32'd0);
            end
        end
    end

    task automatic checkResetState(input string tag);
        checkOutput({tag, ".cpu_gnt"}, 32'(cpu_gnt), 32'd0);
        checkOutput({tag, ".dma_gnt"}, 32'(dma_gnt), 32'd0);
        checkOutput({tag, ".addr"}, DMEM_address, 32'd0);
        checkOutput({tag, ".wdata"}, DMEM_data_in, 32'd0);
        checkOutput({tag, ".mem_write"}, 32'(DMEM_mem_write), 32'd0);
        checkOutput({tag, ".mem_read"}, 32'(DMEM_mem_read), 32'd0);
        checkOutput({tag, ".cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
        checkOutput({tag, ".dma_rvalid"}, 32'(dma_rvalid), 32'd0);
        checkOutput({tag, ".cpu_rdata"}, cpu_rdata, 32'd0);
        checkOutput({tag, ".dma_rdata"}, dma_rdata, 32'd0);
        checkOutput({tag, ".cpu_err"}, 32'(cpu_err), 32'd0);
        checkOutput({tag, ".dma_err"}, 32'(dma_err), 32'd0);
    endtask

    initial begin : stimulus
        logic [31:0] b2bAddr [3];
        logic [31:0] b2bData [3];
        logic        dmaWins;

        b2bAddr[0] = 32'd7; b2bData[0] = 32'h1234_5678;
        b2bAddr[1] = 32'd3; b2bData[1] = 32'hDEAD_BEEF;
        b2bAddr[2] = 32'd5; b2bData[2] = 32'hA000_0005;

        // Reset with requests pending: nothing may be granted.
        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b1, 32'd3, 32'h1111_1111, 1'b1, 1'b0, 32'd2, 32'd0);
        #2;
        checkResetState("reset");
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // CPU write then read back.
        applyStimulus(1'b1, 1'b1, 32'd3, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle("cpu_wr3", 1'b1, 1'b0, 32'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        expectResp(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        runCycle("cpu_rd3", 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle("idle0", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // DMA read alone is granted immediately.
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd7, 32'd0);
        expectResp(1'b0, 1'b1, 1'b0, 32'h1234_5678);
        runCycle("dma_rd7", 1'b0, 1'b1, 32'd7, 32'd0, 1'b0, 1'b1);

        // Back-to-back CPU reads keep rvalid high with fresh data.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, b2bAddr[i], 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
            expectResp(1'b1, 1'b1, 1'b0, b2bData[i]);
            runCycle("cpu_b2b", 1'b1, 1'b0, b2bAddr[i], 32'd0, 1'b0, 1'b1);
        end

        // Continuous contention: CPU wins four cycles, DMA forced on the fifth.
        applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            dmaWins = (k == 5) || (k == 10);
            if (dmaWins) expectResp(1'b0, 1'b1, 1'b0, 32'hA000_0002);
            else         expectResp(1'b1, 1'b1, 1'b0, 32'hA000_0001);
            runCycle("contend", !dmaWins, dmaWins, dmaWins ? 32'd2 : 32'd1, 32'd0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle("idle1", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Addresses at and past DEPTH.
        applyStimulus(1'b1, 1'b1, 32'd21, 32'h0000_0055, 1'b0, 1'b0, 32'd0, 32'd0);
        if (BOUNDS) expectResp(1'b1, 1'b0, 1'b1, 32'd0);
        runCycle("cpu_wr21", 1'b1, 1'b0, 32'd21, 32'h0000_0055, !BOUNDS, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'd22, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        expectResp(1'b1, 1'b1, BOUNDS, BOUNDS ? 32'd0 : 32'hA000_0016);
        runCycle("cpu_rd22", 1'b1, 1'b0, 32'd22, 32'd0, 1'b0, !BOUNDS);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd40, 32'd0);
        expectResp(1'b0, 1'b1, BOUNDS, BOUNDS ? 32'd0 : 32'hA000_0008);
        runCycle("dma_rd40", 1'b0, 1'b1, 32'd40, 32'd0, 1'b0, !BOUNDS);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle("idle2", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Build up DMA wait count, then reset right after a CPU read grant.
        applyStimulus(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        expectResp(1'b1, 1'b1, 1'b0, 32'hA000_0001);
        runCycle("pre_rst1", 1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 32'd3, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
        runCycle("pre_rst2", 1'b1, 1'b0, 32'd3, 32'd0, 1'b0, 1'b1);
        checkOutput("pre_rst.cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        checkOutput("pre_rst.cpu_rdata", cpu_rdata, 32'hDEAD_BEEF);
        rst_n = 1'b0;
        #1;
        checkResetState("mid_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Wait count must have cleared: DMA again waits the full four cycles.
        for (int k = 1; k <= 5; k++) begin
            dmaWins = (k == 5);
            if (dmaWins) expectResp(1'b0, 1'b1, 1'b0, 32'hA000_0002);
            else         expectResp(1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
            runCycle("post_rst", !dmaWins, dmaWins, dmaWins ? 32'd2 : 32'd3, 32'd0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
        runCycle("idle3", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        runCycle("idle4", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        checkOutput("cpu_queue_drained", 32'(cpuQ.size()), 32'd0);
        checkOutput("dma_queue_drained", 32'(dmaQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

endmodule
